fsm_seq_ctrl: RTL and testbench
===============================

FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning stimulus pattern width in bits.
REQ-002 SHALL have parameter LOOP_W, default 4, meaning loop-count width.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the watchdog limit in cycles without a loop wrap.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 SHALL have port pattern, input, PAT_W bits: bit sequence driven to the controlled machine, LSB first.
REQ-008 SHALL have port pat_len, input, $clog2(PAT_W) bits: index of the last pattern bit per pass (pass length = pat_len+1).
REQ-009 SHALL have port loop_cnt, input, LOOP_W bits: number of full state loops required.
REQ-010 SHALL have port fsm_state, input, 2 bits: cur_state of the controlled 4-state machine.
REQ-011 SHALL have port fsm_out, input, 1 bit: out of the controlled machine, observed only.
REQ-012 SHALL have port fsm_in, output, 1 bit: drives the in port of the controlled machine.
REQ-013 SHALL have port fsm_rst, output, 1 bit: synchronous reset pulse to the controlled machine.
REQ-014 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1 bit: sticky error, cleared on the next accepted start.
REQ-017 SHALL have port loops_done, output, LOOP_W bits: count of completed loops.

Function
REQ-018 SHALL implement the states IDLE, RSTDUT, DRIVE, DRAIN and FIN.
REQ-019 In IDLE with start=1, SHALL latch pattern, pat_len and loop_cnt, clear loops_done and err, and enter RSTDUT on the next cycle.
REQ-020 RSTDUT SHALL assert fsm_rst for exactly 1 cycle; if the latched loop_cnt=0 it SHALL then go to FIN, otherwise to DRIVE.
REQ-021 DRIVE SHALL set fsm_in = pattern[idx] each cycle, with idx starting at 0, incrementing each cycle, and wrapping to 0 after pat_len.
REQ-022 A loop SHALL be counted, loops_done+1, on the cycle in which fsm_state goes from 2'b11 to 2'b00 (registered previous state compared with current).
REQ-023 When loops_done reaches the latched loop_cnt, SHALL leave DRIVE on the next cycle for DRAIN, even mid-pass.
REQ-024 DRAIN SHALL hold fsm_in=0 for 2 cycles, then go to FIN.
REQ-025 FIN SHALL pulse done for 1 cycle, drop busy on that same cycle, and return to IDLE.
REQ-026 The watchdog SHALL count DRIVE cycles since the last wrap and clear on each wrap.
REQ-027 When the watchdog reaches TIMEOUT, SHALL set err and go to DRAIN.
REQ-028 start while busy SHALL be ignored, with no effect on any latched value.
REQ-029 A wrap and a timeout in the same cycle SHALL be resolved in favour of the wrap: no err, count increments.
REQ-030 loops_done SHALL saturate at its maximum value and never wrap.
REQ-031 fsm_in SHALL be 0 in every state other than DRIVE.

Reset
REQ-032 rst SHALL force IDLE on the next edge from any state, including mid-DRIVE.
REQ-033 Reset values SHALL be fsm_in=0, fsm_rst=0, busy=0, done=0, err=0, loops_done=0, idx=0, watchdog=0.

Configuration
REQ-034 With FSM_SEQ_CHECK_EN defined, in DRIVE any fsm_state change other than +1 mod 4 SHALL set err; the block SHALL continue the run.
REQ-035 Without FSM_SEQ_CHECK_EN, the step checker logic SHALL be absent, and err SHALL come from the watchdog only.

Structure
REQ-036 A shared package fsm_seq_pkg SHALL hold the state enum type and the 2-bit constants S_FIRST=2'b00 and S_LAST=2'b11.
REQ-037 The watchdog SHALL be a sub-module seq_watchdog, with ports clk, rst, clr, en, expired and parameter TIMEOUT.

Verification
REQ-038 Bench SHALL apply start with pattern=8'b0101_0101, pat_len=7, loop_cnt=2, connected to the 4-state machine, and SHALL require: one fsm_rst pulse, loops_done=2, done pulse, err=0.
REQ-039 Bench SHALL apply loop_cnt=0 and SHALL require: fsm_rst pulse, then done 2 cycles after start acceptance, with fsm_in=0 throughout.
REQ-040 Bench SHALL hold fsm_state at 2'b01 during DRIVE and SHALL require: err=1 after 64 cycles, then DRAIN, then done.
REQ-041 Bench SHALL assert rst mid-DRIVE and SHALL require: busy=0, fsm_in=0, loops_done=0 the next cycle.
REQ-042 Bench SHALL pulse start while busy with different inputs and SHALL require: the run is unchanged and loops_done follows the original loop_cnt.
REQ-043 Bench SHALL, with FSM_SEQ_CHECK_EN defined, force fsm_state from 2'b00 to 2'b10 and SHALL require: err=1 the next cycle and the run still completes with done.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// -----------------------------------------------------------------------------
// fsm_seq_pkg
// Shared definitions for the sequence controller:
//   state_t  - controller state encoding
//   S_FIRST  - first state of the controlled 4-state machine (2'b00)
//   S_LAST   - last state of the controlled 4-state machine (2'b11)
//   is_wrap  - previous/current pair forms a completed loop (S_LAST -> S_FIRST)
//   is_step  - current state is exactly one legal +1 (mod 4) step from previous
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package fsm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RSTDUT = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  localparam logic [1:0] S_FIRST = 2'b00;
  localparam logic [1:0] S_LAST  = 2'b11;

  function automatic logic is_wrap(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == S_LAST) && (cur == S_FIRST);
  endfunction

  function automatic logic is_step(input logic [1:0] prev, input logic [1:0] cur);
    return cur == (prev + 2'd1);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts enabled cycles since the last clear and flags the cycle on which the
// count reaches TIMEOUT.
// Parameters:
//   TIMEOUT - number of enabled cycles (without clear) that trips the watchdog
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   clr     - synchronous clear (wins over en)
//   en      - count this cycle
//   expired - combinational: this enabled cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  // r_cnt holds the number of enabled cycles already elapsed, so the
  // TIMEOUT-th enabled cycle is the one that sees TIMEOUT-1.
  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign expired    = en && w_at_limit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fsm_seq_ctrl
// Drives a 4-state machine with a repeating bit pattern (LSB first) until the
// machine has completed loop_cnt full loops (S_LAST -> S_FIRST), then drains
// and reports completion. A watchdog aborts the run with err when no loop
// completes within TIMEOUT drive cycles.
// Optional feature (macro FSM_SEQ_CHECK_EN): in DRIVE, any observed state
// change other than +1 mod 4 sets err; the run continues.
// Parameters: PAT_W (pattern width), LOOP_W (loop count width), TIMEOUT.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start               - run request, sampled only in IDLE
//   pattern, pat_len    - drive bits and index of last bit per pass
//   loop_cnt            - loops required
//   fsm_state, fsm_out  - observed state / output of the controlled machine
//   fsm_in, fsm_rst     - drive input / reset pulse to the controlled machine
//   busy, done, err     - run status (done one-cycle, err sticky)
//   loops_done          - completed loops, saturating
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int LOOP_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W)-1:0] pat_len,
  input  logic [LOOP_W-1:0]        loop_cnt,
  input  logic [1:0]               fsm_state,
  input  logic                     fsm_out,
  output logic                     fsm_in,
  output logic                     fsm_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [LOOP_W-1:0]        loops_done
);

  localparam int IDX_W = $clog2(PAT_W);

  state_t              r_state;
  logic [PAT_W-1:0]    r_pattern;
  logic [IDX_W-1:0]    r_pat_len;
  logic [LOOP_W-1:0]   r_loop_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_prev_state;
  logic                r_drain_cnt;
  logic                r_fsm_in;
  logic                r_fsm_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [LOOP_W-1:0]   r_loops_done;

  logic                w_in_drive;
  logic                w_wrap;
  logic                w_expired;
  logic [LOOP_W-1:0]   w_loops_inc;
  logic                w_unused;

  // The controlled machine's output is observed only.
  assign w_unused = fsm_out;

  assign w_in_drive  = (r_state == ST_DRIVE);
  assign w_wrap      = w_in_drive && is_wrap(r_prev_state, fsm_state);
  assign w_loops_inc = (r_loops_done == {LOOP_W{1'b1}}) ? r_loops_done
                                                        : r_loops_done + 1'b1;

`ifdef FSM_SEQ_CHECK_EN
  logic w_step_bad;
  assign w_step_bad = w_in_drive && (fsm_state != r_prev_state) &&
                      !is_step(r_prev_state, fsm_state);
`endif

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_in_drive || w_wrap),
    .en      (w_in_drive),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pattern    <= '0;
      r_pat_len    <= '0;
      r_loop_cnt   <= '0;
      r_idx        <= '0;
      r_prev_state <= S_FIRST;
      r_drain_cnt  <= 1'b0;
      r_fsm_in     <= 1'b0;
      r_fsm_rst    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_loops_done <= '0;
    end else begin
      r_prev_state <= fsm_state;
      r_done       <= 1'b0;
      r_fsm_rst    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_fsm_in <= 1'b0;
          if (start) begin
            r_pattern    <= pattern;
            r_pat_len    <= pat_len;
            r_loop_cnt   <= loop_cnt;
            r_loops_done <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b1;
            r_fsm_rst    <= 1'b1;
            r_state      <= ST_RSTDUT;
          end
        end

        ST_RSTDUT: begin
          // The controlled machine is being reset this cycle, so its state
          // seen at the start of DRIVE must not be compared with stale history.
          r_prev_state <= S_FIRST;
          if (r_loop_cnt == '0) begin
            r_state <= ST_FIN;
          end else begin
            // fsm_in is registered: preload bit 0 so the first DRIVE cycle
            // already carries it, and idx points at the following bit.
            r_fsm_in <= r_pattern[0];
            r_idx    <= (r_pat_len == '0) ? '0 : IDX_W'(1);
            r_state  <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
`ifdef FSM_SEQ_CHECK_EN
          if (w_step_bad) begin
            r_err <= 1'b1;
          end
`endif
          r_fsm_in <= r_pattern[r_idx];
          r_idx    <= (r_idx == r_pat_len) ? '0 : r_idx + 1'b1;
          // A wrap takes priority over a simultaneous watchdog expiry.
          if (w_wrap) begin
            r_loops_done <= w_loops_inc;
            if (w_loops_inc == r_loop_cnt) begin
              r_fsm_in    <= 1'b0;
              r_idx       <= '0;
              r_drain_cnt <= 1'b0;
              r_state     <= ST_DRAIN;
            end
          end else if (w_expired) begin
            r_err       <= 1'b1;
            r_fsm_in    <= 1'b0;
            r_idx       <= '0;
            r_drain_cnt <= 1'b0;
            r_state     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          r_fsm_in <= 1'b0;
          if (r_drain_cnt) begin
            r_state <= ST_FIN;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end

        ST_FIN: begin
          r_fsm_in <= 1'b0;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_fsm_in <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign fsm_in     = r_fsm_in;
  assign fsm_rst    = r_fsm_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign loops_done = r_loops_done;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsm_seq_ctrl
// Self-checking bench: a simple 4-state machine (advances on in=1, holds on
// in=0, synchronous reset) is connected to the controller. Each run's
// expected drive length, loop count and err are predicted from the pattern
// arithmetic, then every cycle of the run is compared against that prediction.
// Build with FSM_SEQ_CHECK_EN defined to exercise the step checker.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fsm_seq_ctrl;

  localparam int TIMEOUT = 64;

  localparam int M_NORM   = 0;
  localparam int M_STUCK  = 1;
  localparam int M_GLITCH = 2;
  localparam int M_RST    = 3;
  localparam int M_BUSY   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] pat_len;
  logic [3:0] loop_cnt;
  logic [1:0] fsm_state;
  logic       fsm_out;
  logic       fsm_in;
  logic       fsm_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] loops_done;

  logic [1:0] m_state;
  logic       stuck;
  logic       glitch;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Controlled machine
  always_ff @(posedge clk) begin
    if (rst || fsm_rst) m_state <= 2'b00;
    else if (fsm_in)    m_state <= m_state + 2'd1;
  end
  assign fsm_out   = (m_state == 2'b11);
  assign fsm_state = stuck ? 2'b01 : (glitch ? 2'b10 : m_state);

  fsm_seq_ctrl #(
    .PAT_W   (8),
    .LOOP_W  (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .loop_cnt   (loop_cnt),
    .fsm_state  (fsm_state),
    .fsm_out    (fsm_out),
    .fsm_in     (fsm_in),
    .fsm_rst    (fsm_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loops_done (loops_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Prediction from the pattern alone: the machine state in drive cycle d is
  // (ones driven in cycles 1..d-1) mod 4, so a loop completes in cycle d when
  // bit d-1 was a one and that ones count is a multiple of 4.
  task automatic model_run(input logic [7:0] pat, input int len1, input int cnt,
                           output int d_len, output int loops, output bit m_err);
    int ones;
    int since;
    ones  = 0;
    since = 0;
    loops = 0;
    m_err = 1'b0;
    d_len = 0;
    if (cnt == 0) return;
    for (int d = 1; d <= 10000; d++) begin
      if (d > 1 && pat[(d-2) % len1] == 1'b1 && (ones % 4) == 0) begin
        loops = (loops == 15) ? 15 : loops + 1;
        since = 0;
        if (loops == cnt) begin
          d_len = d;
          return;
        end
      end else begin
        since++;
        if (since == TIMEOUT) begin
          m_err = 1'b1;
          d_len = d;
          return;
        end
      end
      ones += int'(pat[(d-1) % len1]);
    end
  endtask

  task automatic run_case(input logic [7:0] pat, input logic [2:0] len,
                          input logic [3:0] cnt, input int mode);
    int d_len;
    int exp_loops;
    bit exp_err;
    int total;
    logic exp_in;
    bit   is_drive;
    model_run(pat, int'(len) + 1, int'(cnt), d_len, exp_loops, exp_err);
    if (mode == M_STUCK && cnt != 0) begin
      d_len     = TIMEOUT;
      exp_loops = 0;
      exp_err   = 1'b1;
    end
`ifdef FSM_SEQ_CHECK_EN
    if (mode == M_GLITCH) exp_err = 1'b1;
`endif
    total = (cnt == 0) ? 3 : 5 + d_len;
    $display("run: pat=%02h len=%0d cnt=%0d mode=%0d drive=%0d loops=%0d err=%0d",
             pat, len, cnt, mode, d_len, exp_loops, exp_err);

    @(negedge clk);
    pattern  = pat;
    pat_len  = len;
    loop_cnt = cnt;
    start    = 1'b1;
    stuck    = (mode == M_STUCK);
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int c = 1; c <= total + 1; c++) begin
      is_drive = (cnt != 0) && (c >= 2) && (c <= 1 + d_len);
      exp_in   = is_drive ? pat[(c-2) % (int'(len) + 1)] : 1'b0;
      check_val("fsm_in", fsm_in, exp_in);
      check_val("fsm_rst", fsm_rst, c == 1);
      check_val("done", done, c == total);
      check_val("busy", busy, c < total);
      if (c == total) begin
        check_val("loops_done", loops_done, exp_loops);
        check_val("err", err, exp_err);
      end
      if (mode == M_STUCK && c == 1 + d_len) check_val("err_before_timeout", err, 0);
      if (mode == M_STUCK && c == 2 + d_len) check_val("err_after_timeout", err, 1);
      if (mode == M_GLITCH) begin
        if (c == 11) check_val("err_after_glitch", err, exp_err);
        glitch = (c == 10);
      end
      if (mode == M_BUSY) begin
        if (c == 5) begin
          start    = 1'b1;
          pattern  = 8'hFF;
          pat_len  = 3'd3;
          loop_cnt = 4'd5;
        end else begin
          start = 1'b0;
        end
      end
      if (mode == M_RST && c == 10) begin
        check_val("loops_before_rst", loops_done, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_busy", busy, 0);
        check_val("rst_fsm_in", fsm_in, 0);
        check_val("rst_loops_done", loops_done, 0);
        check_val("rst_done", done, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    stuck  = 1'b0;
    glitch = 1'b0;
    start  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    pat_len  = '0;
    loop_cnt = '0;
    stuck    = 1'b0;
    glitch   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_fsm_in", fsm_in, 0);
    check_val("reset_fsm_rst", fsm_rst, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_err", err, 0);
    check_val("reset_loops_done", loops_done, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_case(8'b0101_0101, 3'd7, 4'd2, M_NORM);
    run_case(8'b0101_0101, 3'd7, 4'd0, M_NORM);
    run_case(8'b0101_0101, 3'd7, 4'd2, M_STUCK);
    run_case(8'b0101_0101, 3'd7, 4'd2, M_RST);
    run_case(8'b0101_0101, 3'd7, 4'd2, M_BUSY);
    run_case(8'b0101_0101, 3'd7, 4'd2, M_GLITCH);
    run_case(8'b0000_0000, 3'd7, 4'd1, M_NORM);
    run_case(8'hFF,        3'd0, 4'd15, M_NORM);
    run_case(8'b0000_0011, 3'd2, 4'd3, M_NORM);

    for (int t = 0; t < 16; t++) begin
      run_case(8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), M_NORM);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
